// File: rtl/alu_operand_stage_if.sv
// Handshake and bus bundle between the decode/operand stage, its instruction
// source, the write-back port and the downstream ALU/EX stage.
interface alu_operand_stage_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic [WIDTH-1:0] Instr;
    logic             InValid;
    logic             InReady;
    logic             Flush;
    logic             WbEn;
    logic [AW-1:0]    WbAddr;
    logic [WIDTH-1:0] WbData;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       Op;
    logic             Bnegate;
    logic             CIN;
    logic [AW-1:0]    Rd;
    logic             RegWrite;
    logic             OutValid;
    logic             OutReady;
    logic             IllegalInstr;
    logic [15:0]      IssueCount;

    modport slave (
        input  Instr, InValid, Flush, WbEn, WbAddr, WbData, OutReady,
        output InReady, A, B, Op, Bnegate, CIN, Rd, RegWrite, OutValid,
               IllegalInstr, IssueCount
    );

    modport master (
        output Instr, InValid, Flush, WbEn, WbAddr, WbData, OutReady,
        input  InReady, A, B, Op, Bnegate, CIN, Rd, RegWrite, OutValid,
               IllegalInstr, IssueCount
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Decode/operand stage feeding the 16-bit ALU: 8x16 register file with write-back
// bypass and an ID/EX register. Optional issue counter built under ISSUE_CNT_EN.
module alu_operand_stage #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input logic                Clock,
    input logic                Reset,
    alu_operand_stage_if.slave io
);
    localparam int AW = $clog2(NREGS);

    function automatic logic [WIDTH-1:0] sext_imm(input logic [5:0] imm);
        logic signed [WIDTH-1:0] s;
        s = WIDTH'($signed(imm));
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] zext_imm(input logic [5:0] imm);
        return WIDTH'(imm);
    endfunction

    logic [WIDTH-1:0] rf [NREGS];

    logic [3:0]       opcode_p0;
    logic [AW-1:0]    rs_p0, rt_p0, dest_p0;
    logic [2:0]       op_p0;
    logic             bneg_p0, cin_p0, breg_p0, legal_p0;
    logic [WIDTH-1:0] bimm_p0, ra_p0, rb_p0;

    logic [WIDTH-1:0] a_p1, b_p1;
    logic [2:0]       op_p1;
    logic             bneg_p1, cin_p1, rw_p1, vld_p1, ill_p1, breg_p1;
    logic [AW-1:0]    rd_p1, rs_p1, rt_p1;

    logic accept, stall, wb_hit_rs, wb_hit_rt;

    // Stage 0: decode and register-file read with write-back bypass
    always_comb begin
        opcode_p0 = io.Instr[15:12];
        rs_p0     = io.Instr[11:9];
        rt_p0     = io.Instr[8:6];
        dest_p0   = io.Instr[8:6];
        op_p0     = 3'd0;
        bneg_p0   = 1'b0;
        cin_p0    = 1'b0;
        breg_p0   = 1'b0;
        legal_p0  = 1'b1;
        bimm_p0   = zext_imm(io.Instr[5:0]);
        case (opcode_p0)
            4'd0: begin
                breg_p0 = 1'b1;
                dest_p0 = io.Instr[5:3];
                case (io.Instr[2:0])
                    3'b000: op_p0 = 3'd0;
                    3'b001: op_p0 = 3'd2;
                    3'b010: op_p0 = 3'd3;
                    3'b011: op_p0 = 3'd4;
                    3'b100: begin op_p0 = 3'd4; bneg_p0 = 1'b1; cin_p0 = 1'b1; end
                    3'b101: begin op_p0 = 3'd1; bneg_p0 = 1'b1; cin_p0 = 1'b1; end
                    3'b110: op_p0 = 3'd7;
                    default: op_p0 = 3'd6;
                endcase
            end
            4'd1: begin op_p0 = 3'd5; bimm_p0 = sext_imm(io.Instr[5:0]); end
            4'd2: begin
                op_p0   = 3'd1;
                bneg_p0 = 1'b1;
                cin_p0  = 1'b1;
                bimm_p0 = sext_imm(io.Instr[5:0]);
            end
            4'd3: op_p0 = 3'd0;
            4'd4: op_p0 = 3'd2;
            default: legal_p0 = 1'b0;
        endcase

        ra_p0 = '0;
        if (rs_p0 != '0)
            ra_p0 = (io.WbEn && io.WbAddr == rs_p0) ? io.WbData : rf[rs_p0];
        rb_p0 = '0;
        if (rt_p0 != '0)
            rb_p0 = (io.WbEn && io.WbAddr == rt_p0) ? io.WbData : rf[rt_p0];
    end

    assign io.InReady = !vld_p1 || io.OutReady;
    assign accept     = io.InValid && io.InReady;
    assign stall      = vld_p1 && !io.OutReady;
    // A held entry keeps tracking write-back so it never issues a stale operand
    assign wb_hit_rs  = io.WbEn && io.WbAddr != '0 && io.WbAddr == rs_p1;
    assign wb_hit_rt  = io.WbEn && io.WbAddr != '0 && io.WbAddr == rt_p1 && breg_p1;

    // Stage 1: ID/EX register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
            a_p1    <= '0;
            b_p1    <= '0;
            op_p1   <= 3'd0;
            bneg_p1 <= 1'b0;
            cin_p1  <= 1'b0;
            rd_p1   <= '0;
            rw_p1   <= 1'b0;
            rs_p1   <= '0;
            rt_p1   <= '0;
            breg_p1 <= 1'b0;
            vld_p1  <= 1'b0;
            ill_p1  <= 1'b0;
        end else begin
            if (io.WbEn && io.WbAddr != '0)
                rf[io.WbAddr] <= io.WbData;

            ill_p1 <= accept && !legal_p0 && !io.Flush;

            if (io.Flush)
                vld_p1 <= 1'b0;
            else if (accept)
                vld_p1 <= legal_p0;
            else if (io.OutReady)
                vld_p1 <= 1'b0;

            if (!io.Flush && accept && legal_p0) begin
                a_p1    <= ra_p0;
                b_p1    <= breg_p0 ? rb_p0 : bimm_p0;
                op_p1   <= op_p0;
                bneg_p1 <= bneg_p0;
                cin_p1  <= cin_p0;
                rd_p1   <= dest_p0;
                rw_p1   <= (dest_p0 != '0);
                rs_p1   <= rs_p0;
                rt_p1   <= rt_p0;
                breg_p1 <= breg_p0;
            end else if (stall) begin
                if (wb_hit_rs) a_p1 <= io.WbData;
                if (wb_hit_rt) b_p1 <= io.WbData;
            end
        end
    end

    assign io.A            = a_p1;
    assign io.B            = b_p1;
    assign io.Op           = op_p1;
    assign io.Bnegate      = bneg_p1;
    assign io.CIN          = cin_p1;
    assign io.Rd           = rd_p1;
    assign io.RegWrite     = rw_p1;
    assign io.OutValid     = vld_p1;
    assign io.IllegalInstr = ill_p1;

`ifdef ISSUE_CNT_EN
    logic [15:0] cnt_p1;

    always_ff @(posedge Clock) begin
        if (Reset)
            cnt_p1 <= 16'd0;
        else if (vld_p1 && io.OutReady && !io.Flush)
            cnt_p1 <= cnt_p1 + 16'd1;
    end

    assign io.IssueCount = cnt_p1;
`else
    assign io.IssueCount = 16'd0;
`endif
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: an instruction-level reference model checked
// every cycle, plus hand-computed expectations along the way.
module tb_alu_operand_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_operand_stage_if ifc ();

    alu_operand_stage dut (
        .Clock (clk),
        .Reset (rst),
        .io    (ifc.slave)
    );

    // Reference tables: R-type by funct, I-type by opcode 1..4
    logic [2:0] rop  [8] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd4, 3'd1, 3'd7, 3'd6};
    logic       rneg [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] iop  [4] = '{3'd5, 3'd1, 3'd0, 3'd2};
    logic       ineg [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       isx  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    logic [15:0] m_rf [8];
    logic [15:0] m_a = '0, m_b = '0, m_cnt = '0;
    logic [2:0]  m_op = '0, m_rd = '0, m_rs = '0, m_rt = '0;
    logic        m_bn = 1'b0, m_rw = 1'b0, m_vld = 1'b0, m_ill = 1'b0, m_breg = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rdval(input logic [2:0] addr);
        if (addr == 3'd0) return 16'h0000;
        if (ifc.WbEn && ifc.WbAddr == addr) return ifc.WbData;
        return m_rf[addr];
    endfunction

    // Reference model: one instruction-level transition per rising edge
    always @(posedge clk) begin
        logic [3:0] opc;
        logic [1:0] ii;
        logic       acc, lg;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_rf[i] = '0;
            m_a = '0; m_b = '0; m_op = '0; m_bn = 0; m_rd = '0; m_rw = 0;
            m_vld = 0; m_ill = 0; m_cnt = '0; m_rs = '0; m_rt = '0; m_breg = 0;
            chk_en = 1'b1;
        end else begin
            opc = ifc.Instr[15:12];
            lg  = (opc <= 4'd4);
            acc = ifc.InValid && (!m_vld || ifc.OutReady);
`ifdef ISSUE_CNT_EN
            if (m_vld && ifc.OutReady && !ifc.Flush) m_cnt = m_cnt + 16'd1;
`endif
            m_ill = acc && !lg && !ifc.Flush;
            if (ifc.Flush) begin
                m_vld = 0;
            end else if (acc && lg) begin
                m_vld = 1;
                m_rs  = ifc.Instr[11:9];
                m_rt  = ifc.Instr[8:6];
                m_a   = rdval(m_rs);
                if (opc == 4'd0) begin
                    m_breg = 1;
                    m_op   = rop[ifc.Instr[2:0]];
                    m_bn   = rneg[ifc.Instr[2:0]];
                    m_rd   = ifc.Instr[5:3];
                    m_b    = rdval(m_rt);
                end else begin
                    ii     = 2'(opc - 4'd1);
                    m_breg = 0;
                    m_op   = iop[ii];
                    m_bn   = ineg[ii];
                    m_rd   = m_rt;
                    m_b    = isx[ii] ? {{10{ifc.Instr[5]}}, ifc.Instr[5:0]}
                                     : {10'b0, ifc.Instr[5:0]};
                end
                m_rw = (m_rd != 3'd0);
            end else if (acc || ifc.OutReady) begin
                m_vld = 0;
            end else if (m_vld && ifc.WbEn && ifc.WbAddr != 3'd0) begin
                if (ifc.WbAddr == m_rs) m_a = ifc.WbData;
                if (m_breg && ifc.WbAddr == m_rt) m_b = ifc.WbData;
            end
            if (ifc.WbEn && ifc.WbAddr != 3'd0) m_rf[ifc.WbAddr] = ifc.WbData;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("OutValid", 32'(ifc.OutValid), 32'(m_vld));
            chk("InReady", 32'(ifc.InReady), 32'(!m_vld || ifc.OutReady));
            chk("IllegalInstr", 32'(ifc.IllegalInstr), 32'(m_ill));
            chk("IssueCount", 32'(ifc.IssueCount), 32'(m_cnt));
            if (m_vld) begin
                chk("A", 32'(ifc.A), 32'(m_a));
                chk("B", 32'(ifc.B), 32'(m_b));
                chk("Op", 32'(ifc.Op), 32'(m_op));
                chk("Bnegate", 32'(ifc.Bnegate), 32'(m_bn));
                chk("CIN", 32'(ifc.CIN), 32'(m_bn));
                chk("Rd", 32'(ifc.Rd), 32'(m_rd));
                chk("RegWrite", 32'(ifc.RegWrite), 32'(m_rw));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rtype(input logic [2:0] rs, input logic [2:0] rt,
                                          input logic [2:0] rd, input logic [2:0] fn);
        return {4'h0, rs, rt, rd, fn};
    endfunction

    function automatic logic [15:0] itype(input logic [3:0] opc, input logic [2:0] rs,
                                          input logic [2:0] rt, input logic [5:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    initial begin
        logic [31:0] exp_cnt;
        ifc.Instr = '0; ifc.InValid = 0; ifc.Flush = 0; ifc.WbEn = 0;
        ifc.WbAddr = '0; ifc.WbData = '0; ifc.OutReady = 1;
        step(); step();
        rst = 0;
        chk("rst A", 32'(ifc.A), 'h0);
        chk("rst B", 32'(ifc.B), 'h0);
        chk("rst Op", 32'(ifc.Op), 'h0);
        chk("rst OutValid", 32'(ifc.OutValid), 'h0);
        chk("rst IssueCount", 32'(ifc.IssueCount), 'h0);
        step();
        chk("InReady after reset", 32'(ifc.InReady), 'h1);

        // Load R3, R4 then SUB rd=5, rs=3, rt=4
        ifc.WbEn = 1; ifc.WbAddr = 3'd3; ifc.WbData = 16'h1234; step();
        ifc.WbAddr = 3'd4; ifc.WbData = 16'h0F0F; step();
        ifc.WbEn = 0;
        ifc.Instr = rtype(3'd3, 3'd4, 3'd5, 3'b100); ifc.InValid = 1; step();
        ifc.InValid = 0;
        chk("SUB A", 32'(ifc.A), 'h1234);
        chk("SUB B", 32'(ifc.B), 'h0F0F);
        chk("SUB Op", 32'(ifc.Op), 'h4);
        chk("SUB Bnegate", 32'(ifc.Bnegate), 'h1);
        chk("SUB CIN", 32'(ifc.CIN), 'h1);
        chk("SUB Rd", 32'(ifc.Rd), 'h5);
        chk("SUB RegWrite", 32'(ifc.RegWrite), 'h1);
        chk("SUB OutValid", 32'(ifc.OutValid), 'h1);

        ifc.Instr = itype(4'h1, 3'd0, 3'd2, 6'h3F); ifc.InValid = 1; step();
        chk("ADDI B", 32'(ifc.B), 'hFFFF);
        chk("ADDI A", 32'(ifc.A), 'h0);
        chk("ADDI Op", 32'(ifc.Op), 'h5);
        chk("ADDI Rd", 32'(ifc.Rd), 'h2);
        ifc.Instr = itype(4'h4, 3'd0, 3'd2, 6'h3F); step();
        ifc.InValid = 0;
        chk("ORI B", 32'(ifc.B), 'h003F);
        chk("ORI Op", 32'(ifc.Op), 'h2);

        // Same-cycle write-back bypass, then R0 stays zero
        ifc.WbEn = 1; ifc.WbAddr = 3'd1; ifc.WbData = 16'hBEEF;
        ifc.Instr = rtype(3'd1, 3'd0, 3'd6, 3'b000); ifc.InValid = 1; step();
        ifc.InValid = 0;
        chk("bypass A", 32'(ifc.A), 'hBEEF);
        chk("AND Op", 32'(ifc.Op), 'h0);
        ifc.WbAddr = 3'd0; ifc.WbData = 16'h5555; step();
        ifc.WbEn = 0;
        ifc.Instr = rtype(3'd0, 3'd0, 3'd7, 3'b000); ifc.InValid = 1; step();
        ifc.InValid = 0;
        chk("R0 read A", 32'(ifc.A), 'h0);

        // Stall with a pending ORI, write-back to the held rs mid-stall
        ifc.Instr = rtype(3'd3, 3'd4, 3'd1, 3'b010); ifc.InValid = 1; step();
        ifc.OutReady = 0;
        ifc.Instr = itype(4'h4, 3'd3, 3'd5, 6'h01);
        #1;
        chk("stall InReady", 32'(ifc.InReady), 'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall A hold", 32'(ifc.A), 'h1234);
            chk("stall InReady hold", 32'(ifc.InReady), 'h0);
        end
        ifc.WbEn = 1; ifc.WbAddr = 3'd3; ifc.WbData = 16'hAAAA; step();
        ifc.WbEn = 0;
        chk("stall update A", 32'(ifc.A), 'hAAAA);
        chk("stall B kept", 32'(ifc.B), 'h0F0F);
        chk("stall Op", 32'(ifc.Op), 'h3);
        ifc.OutReady = 1; step();
        ifc.InValid = 0;
        chk("post-stall A", 32'(ifc.A), 'hAAAA);
        chk("post-stall B", 32'(ifc.B), 'h0001);
        chk("post-stall Rd", 32'(ifc.Rd), 'h5);

        // Illegal opcode 9
        ifc.Instr = 16'h9000; ifc.InValid = 1; step();
        ifc.InValid = 0;
        chk("illegal pulse", 32'(ifc.IllegalInstr), 'h1);
        chk("illegal OutValid", 32'(ifc.OutValid), 'h0);
        step();
        chk("illegal pulse end", 32'(ifc.IllegalInstr), 'h0);

        // Flush while a new instruction is accepted
        ifc.Instr = rtype(3'd3, 3'd4, 3'd2, 3'b011); ifc.InValid = 1; step();
        ifc.Flush = 1; ifc.Instr = rtype(3'd3, 3'd4, 3'd2, 3'b100); step();
        ifc.Flush = 0; ifc.InValid = 0;
        chk("flush OutValid", 32'(ifc.OutValid), 'h0);
        step();
        chk("flush dropped", 32'(ifc.OutValid), 'h0);

        // Reset mid-stall
        ifc.Instr = rtype(3'd3, 3'd4, 3'd1, 3'b101); ifc.InValid = 1; step();
        ifc.OutReady = 0;
        ifc.WbEn = 1; ifc.WbAddr = 3'd6; ifc.WbData = 16'h1111;
        rst = 1; step();
        rst = 0; ifc.InValid = 0; ifc.WbEn = 0; ifc.OutReady = 1;
        chk("midrst A", 32'(ifc.A), 'h0);
        chk("midrst B", 32'(ifc.B), 'h0);
        chk("midrst Bnegate", 32'(ifc.Bnegate), 'h0);
        chk("midrst CIN", 32'(ifc.CIN), 'h0);
        chk("midrst RegWrite", 32'(ifc.RegWrite), 'h0);
        chk("midrst OutValid", 32'(ifc.OutValid), 'h0);
        chk("midrst IssueCount", 32'(ifc.IssueCount), 'h0);

        // Five back-to-back issues; first one proves the register file was cleared
        ifc.Instr = rtype(3'd3, 3'd6, 3'd1, 3'b011); ifc.InValid = 1; step();
        chk("cleared R3", 32'(ifc.A), 'h0);
        chk("cleared R6", 32'(ifc.B), 'h0);
        for (int i = 0; i < 4; i++) begin
            ifc.Instr = itype(4'h1, 3'd0, 3'(i + 1), 6'(i));
            step();
        end
        ifc.InValid = 0;
        step();
`ifdef ISSUE_CNT_EN
        exp_cnt = 'd5;
`else
        exp_cnt = 'd0;
`endif
        chk("IssueCount after 5", 32'(ifc.IssueCount), exp_cnt);
        step(); step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Decode/operand stage directly upstream of the 16-bit ALU. It accepts one 16-bit instruction per handshake and reads two operands from an internal 8x16 register file. It generates the ALU control fields (Op, Bnegate, CIN) and holds everything in an ID/EX pipeline register that feeds the ALU. It also owns the register-file write port used by write-back, with same-cycle bypass.

Parameters:
NREGS, 8, register count (address width 3; R0 hardwired to zero)
WIDTH, 16, datapath width

Ports:
Clock  input  1  single clock; all state updates on rising edge
Reset  input  1  synchronous, active-high
Instr  input  16  instruction word
InValid  input  1  Instr valid
InReady  output  1  stage can accept Instr this cycle
Flush  input  1  discard the pipeline-register contents
WbEn  input  1  register-file write enable
WbAddr  input  3  write address
WbData  input  16  write data
A  output  16  ALU operand A
B  output  16  ALU operand B (register or extended immediate)
Op  output  3  ALU select: 0 AND, 1 SLT, 2 OR, 3 XOR, 4 ADD/SUB, 5 ADDI, 6 SRA, 7 SLL
Bnegate  output  1  invert B in the ALU slices
CIN  output  1  carry-in to bit 0
Rd  output  3  destination register
RegWrite  output  1  instruction writes Rd
OutValid  output  1  pipeline register holds a valid instruction
OutReady  input  1  ALU/EX consumes this cycle
IllegalInstr  output  1  one-cycle pulse on an accepted illegal opcode
IssueCount  output  16  issued-instruction counter (see Optional Feature)

Behaviour:
- Instruction format: opcode[15:12], rs[11:9], rt[8:6], rd[5:3], funct[2:0]; I-type imm6 = [5:0], destination = rt.
- Opcode 0 (R-type) funct decode:
  - 000 AND: Op0
  - 001 OR: Op2
  - 010 XOR: Op3
  - 011 ADD: Op4, Bn=0, CIN=0
  - 100 SUB: Op4, Bn=1, CIN=1
  - 101 SLT: Op1, Bn=1, CIN=1
  - 110 SLL: Op7
  - 111 SRA: Op6
- Opcode 1 ADDI: Op5, B = sign-extended imm6. Opcode 2 SLTI: Op1, Bn=1, CIN=1, B = sign-ext imm6. Opcode 3 ANDI: Op0, zero-ext. Opcode 4 ORI: Op2, zero-ext. All these write rt.
- Opcodes 5..15 are illegal:
  - Accepted, no entry loaded; OutValid goes 0 if the register was consumed.
  - IllegalInstr pulses 1 the following cycle.
- Bnegate=0 and CIN=0 unless stated above. RegWrite=0 when the destination is R0.
- Handshake: InReady = !OutValid | OutReady. Accept = InValid & InReady. On accept of a legal instruction, the register loads and OutValid=1 next cycle (latency 1).
- Consume without accept: OutValid=0 next cycle.
- Stall (OutValid & !OutReady): all outputs hold, InReady=0.
- Flush: OutValid=0 next cycle. Flush has priority over a simultaneous accept, which is dropped; InReady is still reported, and upstream treats the flush cycle as a discard.
- Register file:
  - Reads are combinational at accept. R0 reads 0; writes to R0 are ignored.
  - Write on Clock when WbEn.
  - Bypass: if WbEn and WbAddr==rs (or rt), nonzero, in the accept cycle, the captured operand = WbData.
- Stall update: while stalled, WbEn with nonzero WbAddr matching the held rs (or held rt for R-type) updates the held A (or B) with WbData. Immediate B is never overwritten.
- Reset (any time, including mid-stall or flush):
  - Register file: all entries 0.
  - Outputs: A=B=0, Op=0, Bnegate=CIN=0, Rd=0, RegWrite=0, OutValid=0, IllegalInstr=0, IssueCount=0.
  - InReady=1 the cycle after reset deasserts.

Optional Feature:
ISSUE_CNT_EN
- Defined: IssueCount increments by 1 on each cycle with OutValid & OutReady & !Flush, wraps 0xFFFF->0x0000, cleared by Reset.
- Undefined: IssueCount is tied to 0 and no counter logic is built.

Test Plan:
- Reset; WbEn R3=0x1234, R4=0x0F0F; issue SUB rd=5, rs=3, rt=4, OutReady=1 -> next cycle A=0x1234, B=0x0F0F, Op=4, Bnegate=1, CIN=1, Rd=5, RegWrite=1, OutValid=1.
- ADDI rt=2, rs=0, imm=0x3F -> B=0xFFFF, A=0, Op=5, Rd=2. ORI imm=0x3F -> B=0x003F, Op=2.
- Same-cycle WbEn R1=0xBEEF with accept of AND rs=1 -> A=0xBEEF. WbEn R0=0x5555, then read R0 -> A=0.
- Hold OutReady=0 for 3 cycles with InValid=1 -> InReady=0 and outputs stable. WbEn to held rs=0xAAAA mid-stall -> A=0xAAAA. Release OutReady -> next instruction loads.
- Opcode 0x9 accepted -> IllegalInstr=1 for one cycle, OutValid=0. Flush with a simultaneous accept -> OutValid=0 next cycle, accepted instruction dropped.
- With ISSUE_CNT_EN: 5 consumed instructions -> IssueCount=5. Reset mid-stream -> all outputs 0 and IssueCount=0.
